// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Optional bus-timeout watchdog is enabled by defining MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [1:0]  dm_size,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        o_stall,
    output logic        o_busError,
    output logic [31:0] o_busErrAddr
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DATA  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    state_t      state_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [1:0]  mem_size_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [31:0] if_rdata_r;
    logic [31:0] dm_rdata_r;
    logic        if_ack_r;
    logic        dm_ack_r;
    logic        busy_s;
    logic        timeout_s;
    logic        complete_s;

    assign busy_s     = (state_r == ST_FETCH) || (state_r == ST_DATA);
    assign complete_s = busy_s && (mem_ready || timeout_s);

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          grant_s;
    logic          bus_err_r;
    logic [31:0]   bus_err_addr_r;

    assign grant_s   = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && (dm_req || if_req);
    // The limit is hit on the edge whose increment would reach TIMEOUT_CYCLES.
    assign timeout_s = busy_s && !mem_ready && (cnt_r == CNT_LAST);

    // Wait-cycle counter and sticky error address for the timeout watchdog.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            cnt_r          <= '0;
            bus_err_r      <= 1'b0;
            bus_err_addr_r <= 32'd0;
        end else begin
            bus_err_r <= timeout_s;
            if (timeout_s) begin
                bus_err_addr_r <= mem_addr_r;
            end
            if (grant_s) begin
                cnt_r <= '0;
            end else if (busy_s && !mem_ready) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign o_busError   = bus_err_r;
    assign o_busErrAddr = bus_err_addr_r;
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES == 32'd0);
    assign o_busError   = 1'b0;
    assign o_busErrAddr = 32'd0;
`endif

    // Arbitration FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_size_r  <= 2'b00;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            if_rdata_r  <= NOP_INSN;
            dm_rdata_r  <= 32'd0;
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if_ack_r <= 1'b0;
                    dm_ack_r <= 1'b0;
                    // Data wins: it belongs to the older instruction in the pipeline.
                    if (dm_req) begin
                        state_r     <= ST_DATA;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= dm_we;
                        mem_size_r  <= dm_size;
                        mem_addr_r  <= dm_addr;
                        mem_wdata_r <= dm_wdata;
                    end else if (if_req) begin
                        state_r    <= ST_FETCH;
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_size_r <= 2'b10;
                        mem_addr_r <= if_addr;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                    end
                end
                ST_FETCH, ST_DATA: begin
                    if (complete_s) begin
                        state_r   <= ST_DONE;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        if (state_r == ST_FETCH) begin
                            if_ack_r   <= 1'b1;
                            if_rdata_r <= timeout_s ? 32'd0 : mem_rdata;
                        end else begin
                            dm_ack_r <= 1'b1;
                            if (!mem_we_r) begin
                                dm_rdata_r <= timeout_s ? 32'd0 : mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_req_r <= 1'b0;
                    mem_we_r  <= 1'b0;
                    if_ack_r  <= 1'b0;
                    dm_ack_r  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_size  = mem_size_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign o_stall   = (if_req & ~if_ack_r) | (dm_req & ~dm_ack_r);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        o_stall;
    logic        o_busError;
    logic [31:0] o_busErrAddr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_if_rd;
    logic [31:0] exp_dm_rd;
    logic [31:0] exp_err_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_x(reset_x),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .o_stall(o_stall), .o_busError(o_busError), .o_busErrAddr(o_busErrAddr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Edge numbers are counted from the first edge that sees the new requests.
    task automatic scenario(input bit f_en, input bit d_en, input bit d_we, input logic [1:0] d_sz,
                            input logic [31:0] f_addr, input logic [31:0] d_addr,
                            input logic [31:0] d_wd, input logic [31:0] f_data,
                            input logic [31:0] d_data, input int f_wait, input int d_wait,
                            input bit f_abort, input bit no_ready);
        int  d_g, d_ak, f_g, f_ak, last;
        bit  in_d, in_f, exp_err;
        d_g  = d_en ? 1 : -100;
        d_ak = d_en ? 2 + d_wait : -100;
        f_g  = f_en ? (d_en ? d_ak + 1 : 1) : -100;
        f_ak = f_en ? f_g + 1 + f_wait : -100;
        last = ((d_ak > f_ak) ? d_ak : f_ak) + 1;
        if_req   = f_en;
        if_addr  = f_addr;
        dm_req   = d_en;
        dm_we    = d_we;
        dm_size  = d_sz;
        dm_addr  = d_addr;
        dm_wdata = d_wd;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        for (int e = 1; e <= last; e++) begin
            @(posedge clk);
            #1;
            in_d = d_en && (e >= d_g) && (e < d_ak);
            in_f = f_en && (e >= f_g) && (e < f_ak);
            check_val("mem_req", 32'(mem_req), 32'(in_d | in_f));
            if (in_d) begin
                check_val("dm_mem_addr", mem_addr, d_addr);
                check_val("dm_mem_we", 32'(mem_we), 32'(d_we));
                check_val("dm_mem_size", 32'(mem_size), 32'(d_sz));
                check_val("dm_mem_wdata", mem_wdata, d_wd);
            end
            if (in_f) begin
                check_val("if_mem_addr", mem_addr, f_addr);
                check_val("if_mem_we", 32'(mem_we), 32'd0);
                check_val("if_mem_size", 32'(mem_size), 32'd2);
            end
            if (!in_d && !in_f) begin
                check_val("idle_mem_we", 32'(mem_we), 32'd0);
            end
            check_val("dm_ack", 32'(dm_ack), 32'(e == d_ak));
            check_val("if_ack", 32'(if_ack), 32'(e == f_ak));
            check_val("stall", 32'(o_stall),
                      32'((if_req & (e != f_ak)) | (dm_req & (e != d_ak))));
`ifdef MEMARB_TIMEOUT_EN
            exp_err = no_ready && (e == d_ak);
`else
            exp_err = 1'b0;
`endif
            check_val("bus_error", 32'(o_busError), 32'(exp_err));
            if (exp_err) begin
                exp_err_addr = d_addr;
            end
            check_val("bus_err_addr", o_busErrAddr, exp_err_addr);
            if (e == d_ak) begin
                if (!d_we) begin
                    exp_dm_rd = no_ready ? 32'd0 : d_data;
                end
                check_val("dm_rdata", dm_rdata, exp_dm_rd);
                dm_req = 1'b0;
            end
            if (e == f_ak) begin
                exp_if_rd = f_data;
                check_val("if_rdata", if_rdata, exp_if_rd);
                if_req = 1'b0;
            end
            if (f_abort && (e == f_g)) begin
                if_req = 1'b0;
            end
            // Bench-side memory: ready after the chosen number of wait cycles.
            if (in_d && (e + 1 < d_ak)) begin
                mem_ready = 1'(!no_ready && (e == d_g + d_wait));
            end else if (in_f && (e + 1 < f_ak)) begin
                mem_ready = 1'(e == f_g + f_wait);
            end else if (d_en && (e == d_ak - 1)) begin
                mem_ready = 1'(!no_ready);
            end else if (f_en && (e == f_ak - 1)) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (mem_ready && d_en && (e == d_ak - 1)) begin
                mem_rdata = d_data;
            end else if (mem_ready && f_en && (e == f_ak - 1)) begin
                mem_rdata = f_data;
            end else begin
                mem_rdata = $urandom;
            end
        end
        check_val("if_rdata_hold", if_rdata, exp_if_rd);
        check_val("dm_rdata_hold", dm_rdata, exp_dm_rd);
    endtask

    // Load that never completes, then reset lands in the middle of it.
    task automatic reset_mid_data(input int busy_edges);
        if_req    = 1'b0;
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_size   = 2'b10;
        dm_addr   = 32'h0004_0000;
        mem_ready = 1'b0;
        for (int e = 1; e <= busy_edges; e++) begin
            @(posedge clk);
            #1;
            check_val("stuck_mem_req", 32'(mem_req), 32'd1);
            check_val("stuck_dm_ack", 32'(dm_ack), 32'd0);
            check_val("stuck_bus_error", 32'(o_busError), 32'd0);
        end
        reset_x = 1'b0;
        #1;
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_dm_ack", 32'(dm_ack), 32'd0);
        check_val("rst_if_ack", 32'(if_ack), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_size", 32'(mem_size), 32'd0);
        check_val("rst_dm_rdata", dm_rdata, 32'd0);
        dm_req = 1'b0;
        @(negedge clk);
        reset_x = 1'b1;
        exp_if_rd    = 32'h0000_0013;
        exp_dm_rd    = 32'd0;
        exp_err_addr = 32'd0;
        @(posedge clk);
        #1;
        check_val("post_rst_mem_req", 32'(mem_req), 32'd0);
        check_val("post_rst_if_rdata", if_rdata, 32'h0000_0013);
    endtask

    initial begin
        bit        f_en, d_en, d_we, ab;
        logic [1:0] sz;
        reset_x   = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'd0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_size   = 2'b00;
        dm_addr   = 32'd0;
        dm_wdata  = 32'd0;
        mem_rdata = 32'd0;
        mem_ready = 1'b0;
        exp_if_rd    = 32'h0000_0013;
        exp_dm_rd    = 32'd0;
        exp_err_addr = 32'd0;
        #12;
        check_val("reset_mem_req", 32'(mem_req), 32'd0);
        check_val("reset_mem_we", 32'(mem_we), 32'd0);
        check_val("reset_mem_size", 32'(mem_size), 32'd0);
        check_val("reset_mem_addr", mem_addr, 32'd0);
        check_val("reset_mem_wdata", mem_wdata, 32'd0);
        check_val("reset_if_rdata", if_rdata, 32'h0000_0013);
        check_val("reset_dm_rdata", dm_rdata, 32'd0);
        check_val("reset_acks", 32'({if_ack, dm_ack}), 32'd0);
        check_val("reset_bus_error", 32'(o_busError), 32'd0);
        check_val("reset_bus_err_addr", o_busErrAddr, 32'd0);
        check_val("reset_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        reset_x = 1'b1;

        scenario(1'b1, 1'b0, 1'b0, 2'b00, 32'h0001_0000, 32'd0, 32'd0,
                 32'h0050_0093, 32'd0, 0, 0, 1'b0, 1'b0);
        scenario(1'b0, 1'b1, 1'b1, 2'b00, 32'd0, 32'h0002_0004, 32'h0000_00AB,
                 32'd0, 32'h1234_5678, 0, 3, 1'b0, 1'b0);
        scenario(1'b1, 1'b1, 1'b0, 2'b10, 32'h0001_0004, 32'h0002_0010, 32'd0,
                 32'h0000_0033, 32'hDEAD_BEEF, 1, 0, 1'b0, 1'b0);
        scenario(1'b1, 1'b0, 1'b0, 2'b00, 32'h0001_0008, 32'd0, 32'd0,
                 32'h00A0_0113, 32'd0, 2, 0, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            f_en = 1'($urandom_range(0, 1));
            d_en = 1'($urandom_range(0, 1));
            if (!f_en && !d_en) begin
                d_en = 1'b1;
            end
            d_we = 1'($urandom_range(0, 1));
            ab   = 1'($urandom_range(0, 3) == 0);
            sz   = 2'($urandom_range(0, 2));
            scenario(f_en, d_en, d_we, sz, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom_range(0, TO - 1), $urandom_range(0, TO - 1), ab, 1'b0);
        end

`ifdef MEMARB_TIMEOUT_EN
        scenario(1'b0, 1'b1, 1'b0, 2'b10, 32'd0, 32'h0003_0000, 32'd0,
                 32'd0, 32'hFFFF_FFFF, 0, TO - 1, 1'b0, 1'b1);
        reset_mid_data(2);
`else
        reset_mid_data(3 * TO);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
